// File: rtl/trivium_sched_pkg.sv
// Shared types and constants for the Trivium block scheduler.
package trivium_sched_pkg;
  localparam int KEY_WIDTH   = 80;
  localparam int IV_WIDTH    = 80;
  localparam int DEF_TIMEOUT = 2048;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUTPUT} state_t;
endpackage

// File: rtl/trivium_sched_watchdog.sv
// Watchdog counter: clears in LOAD, counts in RUN, flags terminal count.
module trivium_sched_watchdog #(
  parameter int TIMEOUT = 2048,
  localparam int W = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TIMEOUT - 1));

  // Saturates at terminal count so it can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr)     cnt <= '0;
    else if (en && !tc) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/trivium_block_scheduler.sv
// Drives a Trivium generator through N counter-mode IV blocks per command.
module trivium_block_scheduler
  import trivium_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NB_WIDTH   = 16,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [KEY_WIDTH-1:0]  cmd_key,
  input  logic [IV_WIDTH-1:0]   cmd_iv,
  input  logic [NB_WIDTH-1:0]   cmd_nblocks,
  input  logic                  abort,
  output logic                  gen_rst,
  output logic [KEY_WIDTH-1:0]  gen_key,
  output logic [IV_WIDTH-1:0]   gen_iv,
  input  logic                  gen_end_block,
  input  logic [DATA_WIDTH-1:0] gen_block,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NB_WIDTH-1:0]   out_index,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);
  state_t              state;
  logic [NB_WIDTH-1:0] remaining;
  logic [NB_WIDTH-1:0] index;
  logic                wd_tc;

  trivium_sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk (clk),
    .rst (rst),
    .clr (state == LOAD),
    .en  (state == RUN),
    .tc  (wd_tc)
  );

  // Outputs are registered alongside each transition so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gen_rst     <= 1'b1;
      cmd_ready   <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      gen_key     <= '0;
      gen_iv      <= '0;
      remaining   <= '0;
      index       <= '0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      gen_rst   <= 1'b1;
      cmd_ready <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && !abort) begin
            gen_key     <= cmd_key;
            gen_iv      <= cmd_iv;
            remaining   <= cmd_nblocks;
            index       <= '0;
            timeout_err <= 1'b0;
            if (cmd_nblocks == '0) begin
              done <= 1'b1;
            end else begin
              state     <= LOAD;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        LOAD: begin
          state   <= RUN;
          gen_rst <= 1'b0;
        end
        RUN: begin
          if (gen_end_block) begin
            state     <= OUTPUT;
            gen_rst   <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= gen_block;
            out_index <= index;
          end else if (wd_tc) begin
            state       <= IDLE;
            gen_rst     <= 1'b1;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - NB_WIDTH'(1);
            index     <= index + NB_WIDTH'(1);
            gen_iv    <= gen_iv + IV_WIDTH'(1);
            if (remaining == NB_WIDTH'(1)) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: begin
          state     <= IDLE;
          gen_rst   <= 1'b1;
          cmd_ready <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
